// File: rtl/jtag_bridge_pkg.sv
// rtl/jtag_bridge_pkg.sv - shared types and constants for the JTAG register bridge
package jtag_bridge_pkg;

  // Default register-bus geometry and ack timeout (jtck cycles)
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 255;

  // Status bit positions inside the captured address field
  localparam int STAT_BUSY = 0;
  localparam int STAT_ERR  = 1;
  localparam int STAT_OVR  = 2;

  // Bus transaction FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/jtag_reg_bridge.sv
// rtl/jtag_reg_bridge.sv - JTAG ER1 data register to register-bus master bridge
module jtag_reg_bridge
  import jtag_bridge_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              jtck,
  input  logic              jrstn,
  input  logic              jtdi,
  input  logic              jshift,
  input  logic              jupdate,
  input  logic              jce1,
  output logic              jtdo1,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  // Scan chain layout: [W-1] we, [W-2:DATA_W] addr, [DATA_W-1:0] data
  localparam int         W          = 1 + ADDR_W + DATA_W;
  localparam logic [7:0] TIMER_LOAD = 8'(TIMEOUT);

  state_t            state;
  state_t            state_nxt;
  logic [W-1:0]      sr;
  logic [DATA_W-1:0] rdata_q;
  logic [7:0]        timer;
  logic              err;
  logic              ovr;
  logic              er1_sel;
  logic [ADDR_W-1:0] status;

  logic capture;
  logic shift;
  logic update;
  logic busy;
  logic start;
  logic ack_hit;
  logic timeout_hit;

  assign capture     = jce1 & ~jshift;
  assign shift       = jce1 & jshift;
  // Update-DR is shared by every user register; only act when ER1 was the one scanned
  assign update      = jupdate & er1_sel;
  assign busy        = (state != IDLE);
  assign start       = update & ~busy;
  assign ack_hit     = (state == REQ) & bus_ack;
  // Timer reaching zero on this edge: the last REQ cycle without an ack
  assign timeout_hit = (state == REQ) & ~bus_ack & (timer == 8'd1);
  assign jtdo1       = sr[0];

  // Status word presented in the address field on capture
  always_comb begin
    status            = '0;
    status[STAT_BUSY] = busy;
    status[STAT_ERR]  = err;
    status[STAT_OVR]  = ovr;
  end

  // Shift register: parallel load on capture, LSB-first shift toward jtdo1
  always_ff @(posedge jtck or negedge jrstn) begin
    if (!jrstn) begin
      sr <= '0;
    end else if (capture) begin
      sr <= {1'b0, status, rdata_q};
    end else if (shift) begin
      sr <= {jtdi, sr[W-1:1]};
    end
  end

  // Remember whether ER1 was the selected register until its update is consumed
  always_ff @(posedge jtck or negedge jrstn) begin
    if (!jrstn) begin
      er1_sel <= 1'b0;
    end else if (jce1) begin
      er1_sel <= 1'b1;
    end else if (jupdate) begin
      er1_sel <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge jtck or negedge jrstn) begin
    if (!jrstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     if (ack_hit || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: request is asserted for the whole REQ state
  always_comb begin
    bus_req = (state == REQ);
  end

  // Latch the command from the scan chain when a transaction starts
  always_ff @(posedge jtck or negedge jrstn) begin
    if (!jrstn) begin
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else if (start) begin
      bus_we    <= sr[W-1];
      bus_addr  <= sr[W-2:DATA_W];
      bus_wdata <= sr[DATA_W-1:0];
    end
  end

  // Ack timeout counter, reloaded at every transaction start
  always_ff @(posedge jtck or negedge jrstn) begin
    if (!jrstn) begin
      timer <= '0;
    end else if (start) begin
      timer <= TIMER_LOAD;
    end else if ((state == REQ) && !bus_ack) begin
      timer <= timer - 8'd1;
    end
  end

  // Read data is captured only on an acked read; a timeout keeps the old value
  always_ff @(posedge jtck or negedge jrstn) begin
    if (!jrstn) begin
      rdata_q <= '0;
    end else if (ack_hit && !bus_we) begin
      rdata_q <= bus_rdata;
    end
  end

  // Sticky error flag: set on timeout, cleared by capture, set has priority
  always_ff @(posedge jtck or negedge jrstn) begin
    if (!jrstn) begin
      err <= 1'b0;
    end else if (timeout_hit) begin
      err <= 1'b1;
    end else if (capture) begin
      err <= 1'b0;
    end
  end

  // Sticky overrun flag: set when a command arrives while busy, cleared by capture
  always_ff @(posedge jtck or negedge jrstn) begin
    if (!jrstn) begin
      ovr <= 1'b0;
    end else if (update && busy) begin
      ovr <= 1'b1;
    end else if (capture) begin
      ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_reg_bridge.sv
// tb/tb_jtag_reg_bridge.sv - directed self-checking bench for jtag_reg_bridge
module tb_jtag_reg_bridge;
  import jtag_bridge_pkg::*;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;
  localparam int W       = 1 + ADDR_W + DATA_W;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  logic              jtck      = 1'b0;
  logic              jrstn     = 1'b0;
  logic              jtdi      = 1'b0;
  logic              jshift    = 1'b0;
  logic              jupdate   = 1'b0;
  logic              jce1      = 1'b0;
  logic              jtdo1;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata = '0;
  logic              bus_ack   = 1'b0;

  int   checks = 0;
  int   errors = 0;
  txn_t exp_q[$];
  logic req_prev = 1'b0;

  always #5 jtck = ~jtck;

  jtag_reg_bridge #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .jtck     (jtck),
    .jrstn    (jrstn),
    .jtdi     (jtdi),
    .jshift   (jshift),
    .jupdate  (jupdate),
    .jce1     (jce1),
    .jtdo1    (jtdo1),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ack  (bus_ack)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge jtck);
    #1;
  endtask

  // Scoreboard: every new bus request must match the oldest issued command
  always @(negedge jtck) begin
    if (bus_req && !req_prev) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected_req observed=%0h expected=none", bus_addr);
      end
      if (exp_q.size() != 0) begin
        txn_t e;
        e = exp_q.pop_front();
        check("sb_we", bus_we, e.we);
        check("sb_addr", bus_addr, e.addr);
        check("sb_wdata", bus_wdata, e.wdata);
      end
    end
    req_prev = bus_req;
  end

  // Capture then shift W bits through ER1; out[i] is the i-th bit seen on jtdo1
  task automatic scan_dr(input logic [W-1:0] cmd, output logic [W-1:0] out);
    jce1 = 1'b1; jshift = 1'b0;
    tick();
    jshift = 1'b1;
    for (int i = 0; i < W; i++) begin
      out[i] = jtdo1;
      jtdi   = cmd[i];
      tick();
    end
    jce1 = 1'b0; jshift = 1'b0; jtdi = 1'b0;
    tick();
  endtask

  task automatic send_cmd(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    logic [W-1:0] cmd;
    logic [W-1:0] dummy;
    cmd = {we, addr, data};
    exp_q.push_back(txn_t'(cmd));
    scan_dr(cmd, dummy);
    jupdate = 1'b1;
    tick();
    jupdate = 1'b0;
  endtask

  task automatic er2_pulse(input string tag);
    int seen;
    seen = 0;
    jupdate = 1'b1;
    tick();
    jupdate = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus_req) seen++;
      tick();
    end
    check(tag, seen, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, bus_req, 1'b0);
    check({tag, "_we"}, bus_we, 1'b0);
    check({tag, "_addr"}, bus_addr, 8'h00);
    check({tag, "_wdata"}, bus_wdata, 32'h0);
    check({tag, "_tdo"}, jtdo1, 1'b0);
  endtask

  initial begin
    logic [W-1:0] out;
    int           cnt;

    // Reset state
    #2;
    check_reset_outputs("rst");
    tick();
    jrstn = 1'b1;
    tick();

    // ER2-only update right after reset must not start a transaction
    er2_pulse("er2_after_reset");

    // Write command, ack in the third REQ cycle
    send_cmd(1'b1, 8'h12, 32'hDEADBEEF);
    check("wr_req_n1", bus_req, 1'b1);
    tick();
    check("wr_req_c2", bus_req, 1'b1);
    tick();
    check("wr_addr_stable", bus_addr, 8'h12);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    check("wr_req_drop", bus_req, 1'b0);
    check("wr_state_done", dut.state, DONE);
    tick();
    check("wr_state_idle", dut.state, IDLE);

    // Read command, then read back data and status
    send_cmd(1'b0, 8'h34, 32'h0);
    check("rd_req", bus_req, 1'b1);
    bus_rdata = 32'hCAFEF00D;
    bus_ack   = 1'b1;
    tick();
    bus_ack   = 1'b0;
    bus_rdata = 32'h13579BDF;
    tick();
    scan_dr('0, out);
    check("rd_data", out[DATA_W-1:0], 32'hCAFEF00D);
    check("rd_busy", out[DATA_W+STAT_BUSY], 1'b0);
    check("rd_err", out[DATA_W+STAT_ERR], 1'b0);
    check("rd_ovr", out[DATA_W+STAT_OVR], 1'b0);
    check("rd_we_bit", out[W-1], 1'b0);

    // Stray ack while idle is ignored
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    check("stray_ack_idle", dut.state, IDLE);

    // Timeout: no ack, request lasts TIMEOUT cycles
    send_cmd(1'b0, 8'h56, 32'h0);
    bus_rdata = 32'h0BADF00D;
    cnt = 0;
    while (bus_req && cnt < 20) begin
      cnt++;
      tick();
    end
    check("to_req_cycles", cnt, TIMEOUT);
    tick();
    scan_dr('0, out);
    check("to_status_1", out[DATA_W+2:DATA_W], 3'b010);
    check("to_rdata_kept", out[DATA_W-1:0], 32'hCAFEF00D);
    scan_dr('0, out);
    check("to_status_2", out[DATA_W+2:DATA_W], 3'b000);

    // Overrun: second update while the first command is pending
    send_cmd(1'b1, 8'h78, 32'h11111111);
    jce1 = 1'b1; jshift = 1'b1; jtdi = 1'b1;
    tick();
    jce1 = 1'b0; jshift = 1'b0; jtdi = 1'b0;
    jupdate = 1'b1;
    tick();
    jupdate = 1'b0;
    check("ovr_req_held", bus_req, 1'b1);
    check("ovr_addr_kept", bus_addr, 8'h78);
    check("ovr_wdata_kept", bus_wdata, 32'h11111111);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    tick();
    er2_pulse("er2_after_ovr");
    scan_dr('0, out);
    check("ovr_status_1", out[DATA_W+2:DATA_W], 3'b100);
    scan_dr('0, out);
    check("ovr_status_2", out[DATA_W+2:DATA_W], 3'b000);

    // Asynchronous reset in the middle of a request
    send_cmd(1'b1, 8'hBC, 32'h55AA55AA);
    check("rst_mid_req_before", bus_req, 1'b1);
    @(negedge jtck);
    #1;
    jrstn = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    check("rst_mid_state", dut.state, IDLE);
    tick();
    jrstn = 1'b1;
    tick();
    check("rst_after_req", bus_req, 1'b0);
    scan_dr('0, out);
    check("rst_after_scan", out, {W{1'b0}});

    check("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
